pagerank_mem_arb: RTL and testbench

Two-requester memory arbiter for the PageRank engine: shares one memory request/response port pair (8-bit opaque, 32-bit address, 32-bit data message format) between two requesters, such as the scheduler's two memory ports or two rank-update workers. Grants alternate round-robin on the request side. An in-order tracking FIFO of requester IDs routes each response back to its originator. Sits between the scheduler/workers and the test memory or cache.

---
 rtl/pagerank_mem_arb.sv | 133 +++++++++++++
 tb/tb_pagerank_mem_arb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pagerank_mem_arb.sv
// Two-requester round-robin memory arbiter with an in-order ID FIFO that routes responses back to their originator.
// Optional macro PAGERANK_MEM_ARB_REQ_REG_EN inserts a one-entry registered buffer on the memory request path.
module pagerank_mem_arb #(
  parameter int p_max_outstanding = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [76:0]                          i_req0_msg,
  input  logic                                 i_req0_val,
  output logic                                 o_req0_rdy,
  input  logic [76:0]                          i_req1_msg,
  input  logic                                 i_req1_val,
  output logic                                 o_req1_rdy,
  output logic [46:0]                          o_resp0_msg,
  output logic                                 o_resp0_val,
  input  logic                                 i_resp0_rdy,
  output logic [46:0]                          o_resp1_msg,
  output logic                                 o_resp1_val,
  input  logic                                 i_resp1_rdy,
  output logic [76:0]                          o_mem_req_msg,
  output logic                                 o_mem_req_val,
  input  logic                                 i_mem_req_rdy,
  input  logic [46:0]                          i_mem_resp_msg,
  input  logic                                 i_mem_resp_val,
  output logic                                 o_mem_resp_rdy,
  output logic [$clog2(p_max_outstanding):0]   o_outstanding
);

  localparam int PW = $clog2(p_max_outstanding);
  localparam int CW = PW + 1;

  logic          r_prio;
  logic          r_ids [p_max_outstanding];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic        w_win_val;
  logic        w_win;
  logic [76:0] w_win_msg;
  logic        w_full;
  logic        w_empty;
  logic        w_head;
  logic        w_push;
  logic        w_pop;
  logic        w_head_rdy;

  // Preferred port wins if valid, otherwise fall back to the other port.
  always_comb begin
    w_win_val = i_req0_val | i_req1_val;
    w_win     = r_prio;
    if (!(r_prio ? i_req1_val : i_req0_val)) begin
      w_win = ~r_prio;
    end
  end

  assign w_win_msg  = w_win ? i_req1_msg : i_req0_msg;
  assign w_full     = (r_count == CW'(p_max_outstanding));
  assign w_empty    = (r_count == '0);
  assign w_head     = r_ids[r_rptr];
  assign w_head_rdy = w_head ? i_resp1_rdy : i_resp0_rdy;

`ifdef PAGERANK_MEM_ARB_REQ_REG_EN
  logic        r_buf_val;
  logic [76:0] r_buf_msg;
  logic        w_accept;

  assign w_accept      = ~r_buf_val | i_mem_req_rdy;
  assign w_push        = i_rst_n & w_win_val & ~w_full & w_accept;
  assign o_mem_req_val = i_rst_n & r_buf_val;
  assign o_mem_req_msg = r_buf_msg;
  assign o_req0_rdy    = i_rst_n & w_win_val & ~w_win & w_accept & ~w_full;
  assign o_req1_rdy    = i_rst_n & w_win_val &  w_win & w_accept & ~w_full;

  // The ID is tracked from the moment the request enters the buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf_val <= 1'b0;
      r_buf_msg <= '0;
    end else if (w_accept) begin
      r_buf_val <= w_push;
      if (w_push) begin
        r_buf_msg <= w_win_msg;
      end
    end
  end
`else
  logic w_req_val;

  assign w_req_val     = i_rst_n & w_win_val & ~w_full;
  assign w_push        = w_req_val & i_mem_req_rdy;
  assign o_mem_req_val = w_req_val;
  assign o_mem_req_msg = w_win_msg;
  assign o_req0_rdy    = i_rst_n & w_win_val & ~w_win & i_mem_req_rdy & ~w_full;
  assign o_req1_rdy    = i_rst_n & w_win_val &  w_win & i_mem_req_rdy & ~w_full;
`endif

  assign o_mem_resp_rdy = i_rst_n & ~w_empty & w_head_rdy;
  assign w_pop          = o_mem_resp_rdy & i_mem_resp_val;
  assign o_resp0_val    = i_rst_n & i_mem_resp_val & ~w_empty & ~w_head;
  assign o_resp1_val    = i_rst_n & i_mem_resp_val & ~w_empty &  w_head;
  assign o_resp0_msg    = i_mem_resp_msg;
  assign o_resp1_msg    = i_mem_resp_msg;
  assign o_outstanding  = r_count;

  // Priority only moves on an accepted request so a stalled grant stays put.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < p_max_outstanding; i++) begin
        r_ids[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_ids[r_wptr] <= w_win;
        r_wptr        <= r_wptr + 1'b1;
        r_prio        <= ~w_win;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pagerank_mem_arb.sv
// Directed bench for pagerank_mem_arb (default build, depth 4): a per-cycle vector table
// plus hand-written reset, contention-from-reset and response routing sequences.
module tb_pagerank_mem_arb;

  localparam logic [76:0] REQ0 = {3'd0, 8'h05, 32'h0000_0100, 2'd0, 32'h0000_0000};
  localparam logic [76:0] REQ1 = {3'd1, 8'h0a, 32'h0000_0200, 2'd0, 32'h1234_5678};
  localparam logic [46:0] RESP = {3'd0, 8'h05, 2'd0, 2'd0, 32'hDEAD_BEEF};

  logic        clk;
  logic        rst_n;
  logic [76:0] req0_msg, req1_msg, mem_req_msg;
  logic        req0_val, req1_val, req0_rdy, req1_rdy;
  logic [46:0] resp0_msg, resp1_msg, mem_resp_msg;
  logic        resp0_val, resp1_val, resp0_rdy, resp1_rdy;
  logic        mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
  logic [2:0]  outstanding;

  int checks = 0;
  int failures = 0;

  pagerank_mem_arb #(.p_max_outstanding(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_msg(req0_msg), .i_req0_val(req0_val), .o_req0_rdy(req0_rdy),
    .i_req1_msg(req1_msg), .i_req1_val(req1_val), .o_req1_rdy(req1_rdy),
    .o_resp0_msg(resp0_msg), .o_resp0_val(resp0_val), .i_resp0_rdy(resp0_rdy),
    .o_resp1_msg(resp1_msg), .o_resp1_val(resp1_val), .i_resp1_rdy(resp1_rdy),
    .o_mem_req_msg(mem_req_msg), .o_mem_req_val(mem_req_val), .i_mem_req_rdy(mem_req_rdy),
    .i_mem_resp_msg(mem_resp_msg), .i_mem_resp_val(mem_resp_val), .o_mem_resp_rdy(mem_resp_rdy),
    .o_outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       r0v, r1v, mrdy, rsv, rr0, rr1;
    logic       mval, who, q0, q1, p0, p1, mrs;
    logic [2:0] occ;
  } vec_t;

  vec_t vecs [22];

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_val     = v.r0v;
    req1_val     = v.r1v;
    mem_req_rdy  = v.mrdy;
    mem_resp_val = v.rsv;
    resp0_rdy    = v.rr0;
    resp1_rdy    = v.rr1;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("row%0d", idx);
    checkOutput({tag, " mem_req_val"}, 80'(mem_req_val), 80'(v.mval));
    if (v.mval) checkOutput({tag, " mem_req_msg"}, 80'(mem_req_msg), 80'(v.who ? REQ1 : REQ0));
    checkOutput({tag, " req0_rdy"}, 80'(req0_rdy), 80'(v.q0));
    checkOutput({tag, " req1_rdy"}, 80'(req1_rdy), 80'(v.q1));
    checkOutput({tag, " resp0_val"}, 80'(resp0_val), 80'(v.p0));
    checkOutput({tag, " resp1_val"}, 80'(resp1_val), 80'(v.p1));
    if (v.p0) checkOutput({tag, " resp0_msg"}, 80'(resp0_msg), 80'(RESP));
    if (v.p1) checkOutput({tag, " resp1_msg"}, 80'(resp1_msg), 80'(RESP));
    checkOutput({tag, " mem_resp_rdy"}, 80'(mem_resp_rdy), 80'(v.mrs));
    checkOutput({tag, " outstanding"}, 80'(outstanding), 80'(v.occ));
  endtask

  initial begin
    // Fields: r0v r1v mrdy rsv rr0 rr1 | mval who q0 q1 p0 p1 mrs | occ
    vecs[0]  = {6'b101011, 7'b1010000, 3'd0};
    vecs[1]  = {6'b000111, 7'b0000101, 3'd1};
    vecs[2]  = {6'b000011, 7'b0000000, 3'd0};
    vecs[3]  = {6'b111011, 7'b1101000, 3'd0};
    vecs[4]  = {6'b111111, 7'b1010011, 3'd1};
    vecs[5]  = {6'b111111, 7'b1101101, 3'd1};
    vecs[6]  = {6'b110011, 7'b1000001, 3'd1};
    vecs[7]  = {6'b110011, 7'b1000001, 3'd1};
    vecs[8]  = {6'b111011, 7'b1010001, 3'd1};
    vecs[9]  = {6'b111011, 7'b1101001, 3'd2};
    vecs[10] = {6'b111011, 7'b1010001, 3'd3};
    vecs[11] = {6'b111011, 7'b0000001, 3'd4};
    vecs[12] = {6'b111110, 7'b0000010, 3'd4};
    vecs[13] = {6'b111111, 7'b0000011, 3'd4};
    vecs[14] = {6'b111111, 7'b1101101, 3'd3};
    vecs[15] = {6'b000111, 7'b0000011, 3'd3};
    vecs[16] = {6'b000111, 7'b0000101, 3'd2};
    vecs[17] = {6'b000111, 7'b0000011, 3'd1};
    vecs[18] = {6'b000111, 7'b0000000, 3'd0};
    vecs[19] = {6'b011011, 7'b1101000, 3'd0};
    vecs[20] = {6'b111011, 7'b1010001, 3'd1};
    vecs[21] = {6'b101011, 7'b1010001, 3'd2};

    req0_msg     = REQ0;
    req1_msg     = REQ1;
    mem_resp_msg = RESP;
    rst_n        = 1'b0;
    req0_val     = 1'b1;
    req1_val     = 1'b1;
    mem_req_rdy  = 1'b1;
    mem_resp_val = 1'b1;
    resp0_rdy    = 1'b1;
    resp1_rdy    = 1'b1;

    // Outputs must be forced low while reset is held, even with active inputs.
    @(negedge clk);
    #1;
    checkOutput("reset mem_req_val", 80'(mem_req_val), 80'(0));
    checkOutput("reset req0_rdy", 80'(req0_rdy), 80'(0));
    checkOutput("reset resp0_val", 80'(resp0_val), 80'(0));
    checkOutput("reset mem_resp_rdy", 80'(mem_resp_rdy), 80'(0));
    checkOutput("reset outstanding", 80'(outstanding), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      if (i > 0) @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
    end

    // Three requests are outstanding; pulse reset low between edges.
    @(posedge clk);
    #1;
    checkOutput("pre-reset outstanding", 80'(outstanding), 80'(3));
    req0_val = 1'b1; req1_val = 1'b1; mem_req_rdy = 1'b1;
    mem_resp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset outstanding", 80'(outstanding), 80'(0));
    checkOutput("midreset mem_req_val", 80'(mem_req_val), 80'(0));
    checkOutput("midreset req0_rdy", 80'(req0_rdy), 80'(0));
    checkOutput("midreset req1_rdy", 80'(req1_rdy), 80'(0));
    checkOutput("midreset resp0_val", 80'(resp0_val), 80'(0));
    checkOutput("midreset resp1_val", 80'(resp1_val), 80'(0));
    checkOutput("midreset mem_resp_rdy", 80'(mem_resp_rdy), 80'(0));
    mem_resp_val = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: grants alternate 0,1,0,1 and the FIFO fills.
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checkOutput($sformatf("contend%0d mem_req_val", k), 80'(mem_req_val), 80'(1));
      checkOutput($sformatf("contend%0d mem_req_msg", k), 80'(mem_req_msg), 80'((k % 2) ? REQ1 : REQ0));
      checkOutput($sformatf("contend%0d req0_rdy", k), 80'(req0_rdy), 80'((k % 2) == 0));
      checkOutput($sformatf("contend%0d req1_rdy", k), 80'(req1_rdy), 80'((k % 2) == 1));
      checkOutput($sformatf("contend%0d outstanding", k), 80'(outstanding), 80'(k));
    end

    // Responses return in grant order with no new requests.
    @(negedge clk);
    req0_val = 1'b0; req1_val = 1'b0; mem_resp_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checkOutput($sformatf("route%0d resp0_val", k), 80'(resp0_val), 80'((k % 2) == 0));
      checkOutput($sformatf("route%0d resp1_val", k), 80'(resp1_val), 80'((k % 2) == 1));
      checkOutput($sformatf("route%0d outstanding", k), 80'(outstanding), 80'(4 - k));
    end
    @(negedge clk);
    #1;
    checkOutput("drained outstanding", 80'(outstanding), 80'(0));
    checkOutput("drained mem_resp_rdy", 80'(mem_resp_rdy), 80'(0));
    mem_resp_val = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
